// File: rtl/imem_seq_pkg.sv
// Shared state encodings and default widths for imem_sequencer.
package imem_seq_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int INSTR_W_DEF = 3;
  localparam logic [2:0] STORE_OP_DEF = 3'b010;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_LOAD       = 3'd1;
  localparam state_t ST_FETCH_REQ  = 3'd2;
  localparam state_t ST_FETCH_WAIT = 3'd3;
  localparam state_t ST_HOLD       = 3'd4;
  localparam state_t ST_DONE       = 3'd5;

endpackage

// File: rtl/imem_sequencer.sv
// Loads a host program into instruction SRAM, then replays it to the control unit.
// Define IMEM_SEQ_LOOP_EN to restart fetch at address 0 after the last instruction.
module imem_sequencer
  import imem_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter logic [INSTR_W-1:0] STORE_OP = INSTR_W'(STORE_OP_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_last,
  output logic               load_ready,
  input  logic               run_start,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_wr,
  output logic               mem_rd,
  output logic [INSTR_W-1:0] mem_wr_data,
  input  logic [INSTR_W-1:0] mem_rd_data,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_data,
  input  logic               instr_ready,
  output logic [ADDR_W-1:0]  dmem_addr,
  output logic               dmem_wr_en,
  output logic [ADDR_W:0]    prog_len,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam logic [ADDR_W-1:0] A_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] A_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   L_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]    dmem_addr_q, dmem_addr_d;
  logic                 dmem_wr_en_q, dmem_wr_en_d;
  logic [ADDR_W:0]      prog_len_q, prog_len_d;
  logic [INSTR_W-1:0]   instr_data_q, instr_data_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;

  // Next-state and datapath update for load and fetch sequencing.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wr_en_d = 1'b0;
    prog_len_d   = prog_len_q;
    instr_data_d = instr_data_q;
    done_d       = done_q;
    error_d      = error_q;

    // Data pointer advances the cycle after its write pulse.
    if (dmem_wr_en_q) begin
      dmem_addr_d = dmem_addr_q + A_ONE;
    end else begin
      dmem_addr_d = dmem_addr_q;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (load_start) begin
          state_d  = ST_LOAD;
          wr_ptr_d = '0;
          error_d  = 1'b0;
        end else if (run_start) begin
          rd_ptr_d    = '0;
          dmem_addr_d = '0;
          if (prog_len_q == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_FETCH_REQ;
            done_d  = 1'b0;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (load_valid) begin
          wr_ptr_d = wr_ptr_q + A_ONE;
          // The top address is always the final beat; overflow if host did not say so.
          if (load_last || (wr_ptr_q == A_MAX)) begin
            prog_len_d = {1'b0, wr_ptr_q} + L_ONE;
            error_d    = ~load_last;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_FETCH_REQ: begin
        state_d = ST_FETCH_WAIT;
      end
      ST_FETCH_WAIT: begin
        instr_data_d = mem_rd_data;
        state_d      = ST_HOLD;
      end
      ST_HOLD: begin
        if (instr_ready) begin
          dmem_wr_en_d = (instr_data_q == STORE_OP);
          if (({1'b0, rd_ptr_q} + L_ONE) == prog_len_q) begin
`ifdef IMEM_SEQ_LOOP_EN
            rd_ptr_d = '0;
            state_d  = ST_FETCH_REQ;
`else
            state_d  = ST_DONE;
            done_d   = 1'b1;
`endif
          end else begin
            rd_ptr_d = rd_ptr_q + A_ONE;
            state_d  = ST_FETCH_REQ;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      dmem_addr_q  <= '0;
      dmem_wr_en_q <= 1'b0;
      prog_len_q   <= '0;
      instr_data_q <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wr_en_q <= dmem_wr_en_d;
      prog_len_q   <= prog_len_d;
      instr_data_q <= instr_data_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  // Instruction SRAM port: writes only in LOAD, reads only in FETCH_REQ.
  always_comb begin
    mem_addr    = '0;
    mem_wr      = 1'b0;
    mem_rd      = 1'b0;
    mem_wr_data = '0;
    case (state_q)
      ST_LOAD: begin
        mem_addr    = wr_ptr_q;
        mem_wr      = load_valid;
        mem_wr_data = load_data;
      end
      ST_FETCH_REQ: begin
        mem_addr = rd_ptr_q;
        mem_rd   = 1'b1;
      end
      default: begin
        mem_addr = '0;
      end
    endcase
  end

  assign load_ready  = (state_q == ST_LOAD);
  assign instr_valid = (state_q == ST_HOLD);
  assign busy        = (state_q == ST_LOAD) || (state_q == ST_FETCH_REQ) ||
                       (state_q == ST_FETCH_WAIT) || (state_q == ST_HOLD);
  assign instr_data  = instr_data_q;
  assign dmem_addr   = dmem_addr_q;
  assign dmem_wr_en  = dmem_wr_en_q;
  assign prog_len    = prog_len_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_imem_sequencer.sv
// Self-checking bench for imem_sequencer: transaction-level model plus directed checks.
module tb_imem_sequencer;

  localparam int AW = 16;
  localparam int IW = 3;
  localparam logic [2:0] SOP = 3'b010;
`ifdef IMEM_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0, run_start = 1'b0;
  logic instr_ready = 1'b0;
  logic [IW-1:0] load_data = '0;
  logic [IW-1:0] mem_rd_data;
  logic load_ready, mem_wr, mem_rd, instr_valid, dmem_wr_en, busy, done, error;
  logic [AW-1:0] mem_addr, dmem_addr;
  logic [IW-1:0] mem_wr_data, instr_data;
  logic [AW:0] prog_len;

  logic load_start4 = 1'b0, load_valid4 = 1'b0, load_last4 = 1'b0;
  logic [IW-1:0] load_data4 = '0;
  logic run_start4 = 1'b0, instr_ready4 = 1'b0;
  logic [IW-1:0] mem_rd_data4 = '0;
  logic load_ready4, mem_wr4, mem_rd4, instr_valid4, dmem_wr_en4, busy4, done4, error4;
  logic [3:0] mem_addr4, dmem_addr4;
  logic [IW-1:0] mem_wr_data4, instr_data4;
  logic [4:0] prog_len4;

  always #5 clk = ~clk;

  imem_sequencer dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .run_start(run_start), .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .instr_valid(instr_valid),
    .instr_data(instr_data), .instr_ready(instr_ready), .dmem_addr(dmem_addr),
    .dmem_wr_en(dmem_wr_en), .prog_len(prog_len), .busy(busy), .done(done), .error(error)
  );

  imem_sequencer #(.ADDR_W(4)) dut4 (
    .clk(clk), .rst(rst), .load_start(load_start4), .load_valid(load_valid4),
    .load_data(load_data4), .load_last(load_last4), .load_ready(load_ready4),
    .run_start(run_start4), .mem_addr(mem_addr4), .mem_wr(mem_wr4), .mem_rd(mem_rd4),
    .mem_wr_data(mem_wr_data4), .mem_rd_data(mem_rd_data4), .instr_valid(instr_valid4),
    .instr_data(instr_data4), .instr_ready(instr_ready4), .dmem_addr(dmem_addr4),
    .dmem_wr_en(dmem_wr_en4), .prog_len(prog_len4), .busy(busy4), .done(done4), .error(error4)
  );

  // Instruction SRAM with one-cycle read latency.
  logic [IW-1:0] sram [0:255];
  always @(posedge clk) begin
    if (mem_wr) sram[mem_addr[7:0]] <= mem_wr_data;
    if (mem_rd) mem_rd_data <= sram[mem_addr[7:0]];
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  // Model state: what the sequencer must be doing, in program terms.
  int m_mode = M_IDLE;
  int m_wr = 0, m_len = 0, m_idx = 0, m_store = 0, m_cyc = 0, m_reads = 0;
  bit m_err = 1'b0, m_done = 1'b0, m_pend = 1'b0, m_first = 1'b0;
  logic [IW-1:0] m_prog [0:255];
  int wlog[$];
  int dlog[$];
  int ilog[$];
  int lat = 0;
  int rd_total = 0;

  // Compare process: checks every output every cycle against the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_addrs", {mem_addr, dmem_addr}, 32'd0);
      chk("rst_ctrl", {1'b0, load_ready, mem_wr, mem_rd, mem_wr_data, instr_valid, instr_data,
                       dmem_wr_en, prog_len, busy, done, error}, 32'd0);
      m_mode = M_IDLE; m_len = 0; m_store = 0; m_err = 1'b0; m_done = 1'b0; m_pend = 1'b0;
    end else begin
      chk1("wr_rd_excl", mem_wr & mem_rd, 1'b0);
      chk("prog_len", 32'(prog_len), m_len);
      chk1("error", error, m_err);
      chk1("done", done, m_done);
      chk1("busy", busy, m_mode != M_IDLE);
      chk("dmem_addr", 32'(dmem_addr), m_store & 32'hFFFF);
      chk1("dmem_wr_en", dmem_wr_en, m_pend);
      if (dmem_wr_en) dlog.push_back(int'(dmem_addr));
      if (m_pend) begin m_store++; m_pend = 1'b0; end
      if (mem_rd) rd_total++;
      if (m_mode == M_LOAD) begin
        chk1("load_ready", load_ready, 1'b1);
        chk1("mem_wr", mem_wr, load_valid);
        chk1("mem_rd_load", mem_rd, 1'b0);
        chk1("instr_valid_load", instr_valid, 1'b0);
        if (load_valid) begin
          chk("wr_addr", 32'(mem_addr), m_wr);
          chk("wr_data", 32'(mem_wr_data), 32'(load_data));
          wlog.push_back(int'(mem_addr));
          m_prog[m_wr & 255] = load_data;
          if (load_last || m_wr == 65535) begin
            m_len = m_wr + 1; m_err = !load_last; m_mode = M_IDLE;
          end
          m_wr++;
        end
      end else if (m_mode == M_RUN) begin
        m_cyc++;
        chk1("load_ready_run", load_ready, 1'b0);
        chk1("mem_wr_run", mem_wr, 1'b0);
        if (mem_rd) begin
          chk("rd_addr", 32'(mem_addr), m_idx);
          chk("one_rd_per_instr", m_reads, 0);
          m_reads++;
        end
        if (instr_valid) begin
          if (m_first) begin chk("latency", m_cyc, 3); lat = m_cyc; m_first = 1'b0; end
          chk("instr_data", 32'(instr_data), 32'(m_prog[m_idx & 255]));
          if (instr_ready) begin
            ilog.push_back(int'(instr_data));
            if (instr_data == SOP) m_pend = 1'b1;
            m_reads = 0;
            if (m_idx + 1 == m_len) begin
              if (LOOP) m_idx = 0;
              else begin m_mode = M_IDLE; m_done = 1'b1; end
            end else begin
              m_idx++;
            end
          end
        end
      end else begin
        chk1("mem_wr_idle", mem_wr, 1'b0);
        chk1("mem_rd_idle", mem_rd, 1'b0);
        chk1("instr_valid_idle", instr_valid, 1'b0);
        chk1("load_ready_idle", load_ready, 1'b0);
        if (load_start) begin
          m_mode = M_LOAD; m_wr = 0; m_err = 1'b0;
        end else if (run_start) begin
          m_idx = 0; m_store = 0; m_done = (m_len == 0);
          if (m_len != 0) begin m_mode = M_RUN; m_cyc = 0; m_first = 1'b1; m_reads = 0; end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int max);
    int k;
    k = 0;
    while (!done && k < max) begin tick(); k++; end
    chk1("done_timeout", done, 1'b1);
  endtask

  task automatic load_prog(input logic [IW-1:0] p [], input int n);
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1; load_data = p[i]; load_last = (i == n - 1);
      tick();
    end
    load_valid = 1'b0; load_last = 1'b0;
    tick();
  endtask

  logic [IW-1:0] exp_prog [];
  logic [IW-1:0] first_data;
  int k;

  initial begin
    exp_prog = new[5];
    exp_prog[0] = 3'd1; exp_prog[1] = 3'd2; exp_prog[2] = 3'd1; exp_prog[3] = 3'd0; exp_prog[4] = 3'd3;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Empty program: straight to done, no read.
    run_start = 1'b1; tick(); run_start = 1'b0;
    chk1("empty_done", done, 1'b1);
    chk1("empty_no_rd", mem_rd, 1'b0);
    tick();

    // Load 1,2,1,0,3; load_start wins over run_start, run_start ignored mid-load.
    wlog.delete();
    load_start = 1'b1; run_start = 1'b1; tick(); load_start = 1'b0; run_start = 1'b0;
    chk1("load_wins", load_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1; load_data = exp_prog[i]; load_last = (i == 4);
      tick();
      if (i == 1) begin load_valid = 1'b0; run_start = 1'b1; tick(); run_start = 1'b0; end
    end
    load_valid = 1'b0; load_last = 1'b0;
    tick();
    chk("prog_len5", 32'(prog_len), 32'd5);
    chk1("load_err0", error, 1'b0);
    chk("wlog_n", wlog.size(), 32'd5);
    for (int i = 0; i < wlog.size(); i++) chk("wlog_addr", wlog[i], i);

`ifdef IMEM_SEQ_LOOP_EN
    exp_prog = new[2];
    exp_prog[0] = 3'd2; exp_prog[1] = 3'd2;
    load_prog(exp_prog, 2);
    chk("loop_len", 32'(prog_len), 32'd2);
    dlog.delete();
    instr_ready = 1'b1; run_start = 1'b1; tick(); run_start = 1'b0;
    repeat (30) tick();
    chk1("loop_done0", done, 1'b0);
    chk1("loop_busy", busy, 1'b1);
    chk1("loop_dlog_n", dlog.size() >= 5, 1'b1);
    for (int i = 0; i < 5 && i < dlog.size(); i++) chk("loop_dlog", dlog[i], i);
    rst = 1'b1; tick(); rst = 1'b0; tick();
`else
    // Full-speed run.
    ilog.delete(); dlog.delete(); rd_total = 0; lat = 0;
    instr_ready = 1'b1; run_start = 1'b1; tick(); run_start = 1'b0;
    wait_done(100);
    tick();
    chk("ilog_n", ilog.size(), 32'd5);
    for (int i = 0; i < ilog.size() && i < 5; i++) chk("ilog_data", ilog[i], 32'(exp_prog[i]));
    chk("dlog_n", dlog.size(), 32'd1);
    if (dlog.size() > 0) chk("dlog_addr0", dlog[0], 32'd0);
    chk("lat3", lat, 32'd3);
    chk("rd_total5", rd_total, 32'd5);

    // Stall in HOLD for 4 cycles; load_start there is ignored.
    instr_ready = 1'b0; rd_total = 0;
    run_start = 1'b1; tick(); run_start = 1'b0;
    k = 0;
    while (!instr_valid && k < 10) begin tick(); k++; end
    chk1("stall_valid", instr_valid, 1'b1);
    first_data = instr_data;
    chk("stall_first", 32'(first_data), 32'd1);
    load_start = 1'b1;
    repeat (4) begin
      tick(); load_start = 1'b0;
      chk("stall_data", 32'(instr_data), 32'(first_data));
      chk1("stall_hold", instr_valid, 1'b1);
    end
    chk("stall_rd1", rd_total, 32'd1);
    instr_ready = 1'b1;
    wait_done(100);
    tick();

    // Asynchronous reset while fetching index 2.
    run_start = 1'b1; tick(); run_start = 1'b0;
    k = 0;
    while (!(mem_rd && mem_addr == 16'd2) && k < 40) begin tick(); k++; end
    chk1("reach_rd2", mem_rd && mem_addr == 16'd2, 1'b1);
    rst = 1'b1; #1;
    chk("mid_rst_len", 32'(prog_len), 32'd0);
    chk("mid_rst_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_data", 32'(instr_data), 32'd0);
    chk1("mid_rst_rd", mem_rd, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_valid", instr_valid, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    tick();
`endif

    // Narrow instance: 16 beats without last overflow into error.
    load_start4 = 1'b1; tick(); load_start4 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      load_valid4 = 1'b1; load_data4 = 3'(i);
      if (i == 15) chk("ovf_addr15", 32'(mem_addr4), 32'd15);
      tick();
    end
    load_valid4 = 1'b0;
    chk1("ovf_error", error4, 1'b1);
    chk("ovf_len16", 32'(prog_len4), 32'd16);
    chk1("ovf_idle", load_ready4, 1'b0);
    load_start4 = 1'b1; tick(); load_start4 = 1'b0;
    chk1("ovf_err_clr", error4, 1'b0);
    for (int i = 0; i < 16; i++) begin
      load_valid4 = 1'b1; load_last4 = (i == 15); tick();
    end
    load_valid4 = 1'b0; load_last4 = 1'b0;
    chk1("full_no_err", error4, 1'b0);
    chk("full_len16", 32'(prog_len4), 32'd16);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/imem_sequencer.md
IMEM_SEQUENCER -- requirements
Module: imem_sequencer

Interface
REQ-001 Parameter ADDR_W, 16, SRAM address width for both instruction and data memories.
REQ-002 Parameter INSTR_W, 3, instruction word width.
REQ-003 Parameter STORE_OP, 3'b010, opcode whose retirement schedules a data-SRAM write.
REQ-004 Ports, clock and reset first, SHALL be:
  clk  in  1  single clock, all state on rising edge
  rst  in  1  asynchronous, active-high reset
  load_start  in  1  begin program load
  load_valid  in  1  host instruction beat valid
  load_data  in  INSTR_W  host instruction
  load_last  in  1  beat is final instruction
  load_ready  out  1  sequencer accepts beat
  run_start  in  1  begin fetch of loaded program
  mem_addr  out  ADDR_W  instruction SRAM address
  mem_wr  out  1  instruction SRAM write strobe
  mem_rd  out  1  instruction SRAM read strobe
  mem_wr_data  out  INSTR_W  instruction SRAM write data
  mem_rd_data  in  INSTR_W  instruction SRAM read data, 1-cycle latency
  instr_valid  out  1  instruction offered to control unit
  instr_data  out  INSTR_W  offered instruction
  instr_ready  in  1  control unit accepts instruction
  dmem_addr  out  ADDR_W  data SRAM write pointer
  dmem_wr_en  out  1  one-cycle data SRAM write pulse
  prog_len  out  ADDR_W+1  loaded instruction count
  busy  out  1  state is LOAD or fetch
  done  out  1  program completed, held
  error  out  1  load overflow, sticky until next load_start

Function
REQ-005 States SHALL be IDLE, LOAD, FETCH_REQ, FETCH_WAIT, HOLD, DONE.
REQ-006 IDLE/DONE: load_start -> LOAD with wr_ptr=0, error=0; else run_start -> FETCH_REQ with rd_ptr=0, dmem_addr=0, done=0; load_start wins when both are high.
REQ-007 run_start with prog_len==0 SHALL go to DONE next cycle with no SRAM read.
REQ-008 LOAD: load_ready=1; mem_wr=load_valid, mem_addr=wr_ptr, mem_wr_data=load_data combinationally; each accepted beat increments wr_ptr.
REQ-009 Accepted beat with load_last -> prog_len=wr_ptr+1, state IDLE.
REQ-010 Beat accepted at wr_ptr=2^ADDR_W-1 is implicitly last; prog_len=2^ADDR_W; error=1 if load_last was low.
REQ-011 FETCH_REQ: mem_rd=1, mem_addr=rd_ptr, -> FETCH_WAIT; FETCH_WAIT: register mem_rd_data into instr_data, -> HOLD.
REQ-012 HOLD: instr_valid=1, instr_data stable until instr_valid&&instr_ready; run_start to first instr_valid is exactly 3 cycles.
REQ-013 On handshake with instr_data==STORE_OP: dmem_wr_en=1 for the next cycle with current dmem_addr, then dmem_addr increments (wraps at 2^ADDR_W).
REQ-014 On handshake: rd_ptr+1==prog_len -> DONE (done=1); else rd_ptr++ -> FETCH_REQ.
REQ-015 load_start/run_start SHALL be ignored in LOAD and all fetch states; mem_wr and mem_rd SHALL never both be 1.

Reset
REQ-016 rst SHALL force IDLE, clear wr_ptr, rd_ptr, dmem_addr, prog_len, instr_data and every output to 0, including mid-load or mid-fetch.

Configuration
REQ-017 With IMEM_SEQ_LOOP_EN defined, REQ-014 last-instruction handshake SHALL wrap rd_ptr to 0 and go to FETCH_REQ (done never set, dmem_addr continues); without it, REQ-014 applies.

Structure
REQ-018 Package imem_seq_pkg SHALL hold the state enum, STORE_OP and default widths.
REQ-019 No sub-module; SRAMs remain external instances.

Verification
REQ-020 Load 1,2,1,0,3 (last on 3) -> five writes to addresses 0..4, prog_len=5, error=0.
REQ-021 run_start, instr_ready=1 -> instr_valid 3 cycles later, sequence 1,2,1,0,3, one dmem_wr_en at dmem_addr=0, done=1.
REQ-022 instr_ready low 4 cycles in HOLD -> instr_data stable, no extra mem_rd.
REQ-023 rst asserted mid-fetch at rd_ptr=2 -> IDLE, prog_len=0, all outputs 0 same cycle.
REQ-024 ADDR_W=4, 16 beats without load_last -> error=1, prog_len=16.
REQ-025 IMEM_SEQ_LOOP_EN, program 2,2 -> fetch repeats, dmem_addr 0,1,2,3..., done stays 0.
